// File: rtl/arbitro_rr16.sv
// Round-robin arbiter driving the select bus of a 16-way demux, with one-hot grant and busy flag.
// Optional forced release after TEMPO_MAX grant cycles when ARBITRO_TIMEOUT_EN is defined.
module arbitro_rr16 #(
  parameter int unsigned TEMPO_MAX = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pedido,
  input  logic        libera,
  output logic [3:0]  escolha,
  output logic [15:0] concessao,
  output logic        ativo,
  output logic        expirou
);

  typedef enum logic {StOcioso, StConcedido} estado_e;

  estado_e     estado_q, estado_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  escolha_q, escolha_d;
  logic [15:0] concessao_q, concessao_d;
  logic        ativo_q, ativo_d;
  logic [3:0]  vencedor;
  logic        tem_pedido;
  logic        liberar;
  logic        estouro;

  // Scan from ptr upward with wrap; descending loop so the lowest offset wins.
  always_comb begin
    vencedor   = ptr_q;
    tem_pedido = |pedido;
    for (int i = 15; i >= 0; i--) begin
      if (pedido[ptr_q + 4'(i)]) vencedor = ptr_q + 4'(i);
    end
  end

  assign liberar = libera | ~pedido[escolha_q];

`ifdef ARBITRO_TIMEOUT_EN
  logic [7:0] cont_q, cont_d;
  logic       expirou_q, expirou_d;

  assign estouro = (cont_q == 8'(TEMPO_MAX - 1));
  assign expirou = expirou_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cont_q    <= 8'd0;
      expirou_q <= 1'b0;
    end else begin
      cont_q    <= cont_d;
      expirou_q <= expirou_d;
    end
  end

  always_comb begin
    cont_d    = cont_q;
    expirou_d = 1'b0;
    if (estado_q == StOcioso) begin
      cont_d = 8'd0;
    end else begin
      cont_d = cont_q + 8'd1;
      // A simultaneous normal release takes precedence over the timeout pulse.
      if (estouro && !liberar) expirou_d = 1'b1;
    end
  end
`else
  logic unused_tempo;
  assign unused_tempo = (TEMPO_MAX == 0);
  assign estouro      = 1'b0;
  assign expirou      = 1'b0;
`endif

  always_comb begin
    estado_d    = estado_q;
    ptr_d       = ptr_q;
    escolha_d   = escolha_q;
    concessao_d = concessao_q;
    ativo_d     = ativo_q;
    case (estado_q)
      StOcioso: begin
        if (tem_pedido) begin
          concessao_d = 16'h0001 << vencedor;
          escolha_d   = vencedor;
          ativo_d     = 1'b1;
          estado_d    = StConcedido;
        end
      end
      StConcedido: begin
        if (liberar || estouro) begin
          concessao_d = 16'h0000;
          ativo_d     = 1'b0;
          ptr_d       = escolha_q + 4'd1;
          estado_d    = StOcioso;
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= StOcioso;
      ptr_q       <= 4'd0;
      escolha_q   <= 4'd0;
      concessao_q <= 16'h0000;
      ativo_q     <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      ptr_q       <= ptr_d;
      escolha_q   <= escolha_d;
      concessao_q <= concessao_d;
      ativo_q     <= ativo_d;
    end
  end

  assign escolha   = escolha_q;
  assign concessao = concessao_q;
  assign ativo     = ativo_q;

endmodule

// File: tb/tb_arbitro_rr16.sv
// Scoreboard bench for arbitro_rr16: expected outputs queued per driven cycle, popped after the edge.
module tb_arbitro_rr16;

`ifdef ARBITRO_TIMEOUT_EN
  localparam int unsigned Tempo = 4;
`else
  localparam int unsigned Tempo = 15;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pedido = 16'h0000;
  logic        libera = 1'b0;
  logic [3:0]  escolha;
  logic [15:0] concessao;
  logic        ativo;
  logic        expirou;

  arbitro_rr16 #(.TEMPO_MAX(Tempo)) dut (
    .clock     (clock),
    .reset     (reset),
    .pedido    (pedido),
    .libera    (libera),
    .escolha   (escolha),
    .concessao (concessao),
    .ativo     (ativo),
    .expirou   (expirou)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [15:0] conc;
    logic [3:0]  esc;
    logic        at;
    logic        ex;
  } esperado_t;

  esperado_t fila[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_saidas(input string tag, input logic [15:0] conc, input logic [3:0] esc,
                              input logic at, input logic ex);
    check({tag, " concessao"}, concessao, conc);
    check({tag, " escolha"}, 16'(escolha), 16'(esc));
    check({tag, " ativo"}, 16'(ativo), 16'(at));
    check({tag, " expirou"}, 16'(expirou), 16'(ex));
  endtask

  // Drive one cycle of stimulus (called just after a falling edge) and score the result.
  task automatic ciclo(input string tag, input logic [15:0] ped, input logic lib,
                       input logic [15:0] conc, input logic [3:0] esc, input logic at,
                       input logic ex);
    esperado_t e;
    pedido = ped;
    libera = lib;
    e.tag  = tag;
    e.conc = conc;
    e.esc  = esc;
    e.at   = at;
    e.ex   = ex;
    fila.push_back(e);
    @(posedge clock);
    @(negedge clock);
    e = fila.pop_front();
    check_saidas(e.tag, e.conc, e.esc, e.at, e.ex);
  endtask

  task automatic pulso_reset(input string tag);
    reset = 1'b1;
    #1;
    check_saidas(tag, 16'h0000, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #1;
    check_saidas("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) ciclo("idle", 16'h0000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);

    ciclo("g4", 16'h0010, 1'b0, 16'h0010, 4'd4, 1'b1, 1'b0);
    ciclo("g4 hold", 16'h0010, 1'b0, 16'h0010, 4'd4, 1'b1, 1'b0);
    ciclo("g4 other", 16'h0F1F, 1'b0, 16'h0010, 4'd4, 1'b1, 1'b0);
    ciclo("g4 libera", 16'h0010, 1'b1, 16'h0000, 4'd4, 1'b0, 1'b0);
    ciclo("idle keep esc", 16'h0000, 1'b0, 16'h0000, 4'd4, 1'b0, 1'b0);
    ciclo("ptr after 4", 16'h0031, 1'b0, 16'h0020, 4'd5, 1'b1, 1'b0);
    ciclo("withdraw 5", 16'h0011, 1'b0, 16'h0000, 4'd5, 1'b0, 1'b0);

    pulso_reset("reset pulse");
    for (int k = 0; k < 16; k++) begin
      ciclo($sformatf("rr grant %0d", k), 16'hFFFF, 1'b0, 16'h0001 << k, 4'(k), 1'b1, 1'b0);
      ciclo($sformatf("rr rel %0d", k), 16'hFFFF, 1'b1, 16'h0000, 4'(k), 1'b0, 1'b0);
    end
    ciclo("wrap", 16'h8001, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0);
    ciclo("withdraw 0", 16'h8000, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    ciclo("g15", 16'h8000, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b0);
    ciclo("g15 other", 16'hC003, 1'b0, 16'h8000, 4'd15, 1'b1, 1'b0);
    ciclo("g15 rel", 16'h8000, 1'b1, 16'h0000, 4'd15, 1'b0, 1'b0);
    ciclo("libera idle", 16'h0000, 1'b1, 16'h0000, 4'd15, 1'b0, 1'b0);
    ciclo("g7", 16'h0080, 1'b0, 16'h0080, 4'd7, 1'b1, 1'b0);

    // Assert reset away from any edge; outputs must clear without a clock.
    #2;
    reset = 1'b1;
    #1;
    check_saidas("async reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    ciclo("post reset", 16'h0081, 1'b0, 16'h0001, 4'd0, 1'b1, 1'b0);
    ciclo("post reset rel", 16'h0081, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0);

`ifdef ARBITRO_TIMEOUT_EN
    for (int i = 0; i < 4; i++) ciclo("to grant", 16'h0004, 1'b0, 16'h0004, 4'd2, 1'b1, 1'b0);
    ciclo("to expire", 16'h0004, 1'b0, 16'h0000, 4'd2, 1'b0, 1'b1);
    ciclo("to regrant", 16'h0004, 1'b0, 16'h0004, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) ciclo("to hold2", 16'h0004, 1'b0, 16'h0004, 4'd2, 1'b1, 1'b0);
    ciclo("to tie rel", 16'h0004, 1'b1, 16'h0000, 4'd2, 1'b0, 1'b0);
    ciclo("to prio 3", 16'h000C, 1'b0, 16'h0008, 4'd3, 1'b1, 1'b0);
    ciclo("to prio rel", 16'h000C, 1'b1, 16'h0000, 4'd3, 1'b0, 1'b0);
`else
    for (int i = 0; i < 20; i++) ciclo("long hold", 16'h0004, 1'b0, 16'h0004, 4'd2, 1'b1, 1'b0);
    ciclo("long rel", 16'h0004, 1'b1, 16'h0000, 4'd2, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/arbitro_rr16.md
Name: arbitro_rr16

Overview:
- Round-robin arbiter and sequencer for the 16-way 1-to-16 demultiplexer. It shares one serial data source among 16 requesters.
- It registers the winning requester's index onto the demux select bus (Escolha) and holds that grant until the requester releases.
- It adds a one-hot grant vector and a busy flag, so that downstream logic can qualify the demux outputs.

Parameters:
- TEMPO_MAX, default 15: maximum number of grant cycles before a forced release. Used only when ARBITRO_TIMEOUT_EN is defined. Legal range is 1..255.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Pedido  input  16  request vector; bit i is requester i.
- Libera  input  1  release strobe from the current owner; sampled only while Ativo=1.
- Escolha  output  4  registered demux select; index of the current or most recent grant.
- Concessao  output  16  registered one-hot grant; all zeros when idle.
- Ativo  output  1  registered; 1 while a grant is held.
- Expirou  output  1  registered one-cycle pulse on a forced release. Constant 0 when ARBITRO_TIMEOUT_EN is undefined.

Behaviour:
- Reset (asynchronous, active-high), effective immediately and mid-operation:
  - state=OCIOSO, Concessao=16'h0000, Escolha=4'd0, Ativo=0, Expirou=0.
  - Internal pointer ptr=4'd0; hold counter=0.
  - Any in-progress grant is dropped with no release pulse.
- States: OCIOSO (idle) and CONCEDIDO (granted).
- OCIOSO:
  - If Pedido==0, remain idle. All outputs hold, and Escolha keeps its last value so the demux select stays stable.
  - If Pedido!=0, search indices ptr, ptr+1, ..., ptr+15 (mod 16). The first set bit is the winner g.
  - At the next edge: Concessao=1<<g, Escolha=g, Ativo=1, counter=0, state=CONCEDIDO.
  - Grant latency: 1 cycle from the first cycle Pedido is sampled non-zero.
- CONCEDIDO:
  - The grant holds while Pedido[g]=1 and Libera=0. Changes on other Pedido bits are ignored.
  - Release condition: Libera=1, or Pedido[g]=0 (requester withdrew).
  - On release, at the next edge: Concessao=0, Ativo=0, ptr=(g+1) mod 16 with 4-bit wrap so 15 goes to 0, state=OCIOSO. Escolha keeps g.
- Minimum one idle cycle between consecutive grants; there is no same-cycle handoff. A requester that keeps Pedido high is re-evaluated in OCIOSO behind ptr.
- Fairness: with all 16 bits requesting continuously, grants rotate 0,1,...,15,0. Worst-case wait is 15 grant periods.
- Libera while in OCIOSO is ignored.
- Release and timeout in the same cycle are treated as a normal release: Expirou=0.
- Hold counter: 8 bits, increments each CONCEDIDO cycle, cleared on entry to CONCEDIDO.

Optional Feature:
- Macro: ARBITRO_TIMEOUT_EN.
- Defined:
  - If the counter reaches TEMPO_MAX-1 in CONCEDIDO with no release that cycle, the next edge performs a forced release: same updates as a normal release, plus Expirou=1 for exactly one cycle.
  - Maximum grant duration is TEMPO_MAX cycles.
- Undefined:
  - No counter logic is generated.
  - A grant lasts until Libera or Pedido withdrawal, unbounded.
  - Expirou is tied to 0.

Test Plan:
- Reset released, Pedido=16'h0000 for 5 cycles -> Concessao=0, Escolha=0, Ativo=0 throughout.
- Pedido=16'h0010 at cycle 0 -> cycle 1: Concessao=16'h0010, Escolha=4, Ativo=1. Libera=1 at cycle 3 -> cycle 4: Concessao=0, Ativo=0, Escolha still 4.
- Pedido=16'hFFFF held, Libera pulsed one cycle after each grant -> grants 0,1,2,...,15,0 in order, with one idle cycle between grants.
- After the grant to index 15 releases, Pedido=16'h8001 -> next grant is index 0 (pointer wrap), not 15.
- Grant held on index 7, Reset asserted mid-grant -> outputs clear asynchronously without waiting for an edge. After reset, Pedido=16'h0081 -> grant index 0.
- ARBITRO_TIMEOUT_EN defined, TEMPO_MAX=4, Pedido[2] held with no Libera -> Concessao=16'h0004 for exactly 4 cycles, then cleared with Expirou=1 for one cycle. Next grant goes to index 2 again only after the idle cycle, and only if no request exists at indices 3..15.
